db: RTL and testbench



---
 rtl/db.sv | 64 ++++++
 tb/tb_db.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/db.sv
// Four-channel button debouncer: 2-flop synchroniser, then a stable-run counter per channel.
// Output follows input DEBOUNCE_CYCLES+1 edges after the first sampling edge; no backpressure.
module db #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btnHS,
  output logic HS,
  input  logic btnVS,
  output logic VS,
  input  logic btnDF_UART,
  output logic DF_UART,
  input  logic btnDF_VGA,
  output logic DF_VGA
);

  localparam int                NCH  = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   btn;
  logic [NCH-1:0]   s1_q, s2_q;
  logic [NCH-1:0]   out_q, out_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  assign btn = {btnDF_VGA, btnDF_UART, btnVS, btnHS};

  // A single cycle of agreement between s2 and out restarts qualification.
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != out_q[i]) begin
        if (cnt_q[i] == LAST) begin
          out_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q  <= btn;
      s2_q  <= s1_q;
      out_q <= out_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign HS      = out_q[0];
  assign VS      = out_q[1];
  assign DF_UART = out_q[2];
  assign DF_VGA  = out_q[3];

endmodule

// File: tb/tb_db.sv
// Randomised and directed bench for db, checked every cycle against a history-window model.
module tb_db;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnHS = 1'b0, btnVS = 1'b0, btnDF_UART = 1'b0, btnDF_VGA = 1'b0;
  logic HS, VS, DF_UART, DF_VGA;

  int checks = 0;
  int failures = 0;

  db #(.DEBOUNCE_CYCLES(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .btnHS(btnHS), .HS(HS),
    .btnVS(btnVS), .VS(VS),
    .btnDF_UART(btnDF_UART), .DF_UART(DF_UART),
    .btnDF_VGA(btnDF_VGA), .DF_VGA(DF_VGA)
  );

  always #5 clk = ~clk;

  // Model: per channel, raw samples since reset and the synchronised-value history;
  // output flips once the last N synchronised samples all disagree with it.
  bit bh [4][$];
  bit sh [4][$];
  bit mq [4];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {DF_VGA, DF_UART, VS, HS};
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] b);
    bit s2p;
    bit all_diff;
    for (int c = 0; c < 4; c++) begin
      if (r) begin
        bh[c].delete();
        sh[c].delete();
        mq[c] = 1'b0;
      end else begin
        s2p = (bh[c].size() >= 2) ? bh[c][bh[c].size() - 2] : 1'b0;
        bh[c].push_back(b[c]);
        if (bh[c].size() > 2) void'(bh[c].pop_front());
        sh[c].push_back(s2p);
        if (sh[c].size() > N) void'(sh[c].pop_front());
        if (sh[c].size() == N) begin
          all_diff = 1'b1;
          foreach (sh[c][k]) if (sh[c][k] == mq[c]) all_diff = 1'b0;
          if (all_diff) mq[c] = ~mq[c];
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] b);
    logic [3:0] o;
    rst = r;
    {btnDF_VGA, btnDF_UART, btnVS, btnHS} = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    o = outs();
    chk("HS", o[0], mq[0]);
    chk("VS", o[1], mq[1]);
    chk("DF_UART", o[2], mq[2]);
    chk("DF_VGA", o[3], mq[3]);
  endtask

  // Holds b for a number of edges and reports edges after the first one until
  // channel ch reaches val (-1 if it never does).
  task automatic run_lat(input logic [3:0] b, input int ch, input logic val,
                         input int cycles, input int exp_lat, input string tag);
    int lat;
    logic [3:0] o;
    lat = -1;
    for (int k = 0; k < cycles; k++) begin
      step(1'b0, b);
      o = outs();
      if (lat < 0 && o[ch] == val) lat = k;
    end
    chk(tag, lat, exp_lat);
  endtask

  logic [31:0] pat;
  int          run_start;

  initial begin
    int lat_vs, uart_chg;
    logic [3:0] o, b;
    int hold [4];
    logic [3:0] rb;

    // Reset with all buttons pressed: outputs must stay low.
    step(1'b1, 4'hF);
    chk("rst_out0", outs(), 0);
    step(1'b1, 4'hF);
    chk("rst_out1", outs(), 0);
    run_lat(4'hF, 0, 1'b1, N + 4, N + 1, "rst_rel_HS");
    chk("rst_rel_all", outs(), 4'hF);
    run_lat(4'h0, 3, 1'b0, N + 4, N + 1, "all_release");

    // Clean press and release on btnHS.
    run_lat(4'h1, 0, 1'b1, 20, N + 1, "hs_press");
    chk("hs_press_others", outs() & 4'hE, 0);
    run_lat(4'h0, 0, 1'b0, 15, N + 1, "hs_release");

    // Bounce pattern, LSB first; steady run start derived from the pattern.
    pat = 32'hFFFF_FEAA;
    run_start = 32;
    for (int i = 31; i >= 0; i--) begin
      if (pat[i]) run_start = i;
      else break;
    end
    lat_vs = -1;
    for (int i = 0; i < 32; i++) begin
      step(1'b0, {3'b000, pat[i]});
      o = outs();
      if (lat_vs < 0 && o[0]) lat_vs = i;
    end
    chk("bounce_rise", lat_vs, run_start + N + 1);
    run_lat(4'h0, 0, 1'b0, 15, N + 1, "bounce_release");

    // Glitch on DF_VGA: 7 high, 1 low, 7 high never qualifies.
    run_lat(4'h8, 3, 1'b1, 7, -1, "glitch_a");
    run_lat(4'h0, 3, 1'b1, 1, -1, "glitch_low");
    run_lat(4'h8, 3, 1'b1, 7, -1, "glitch_b");
    run_lat(4'h0, 3, 1'b1, 12, -1, "glitch_idle");
    run_lat(4'h8, 3, 1'b1, 12, N + 1, "vga_long");
    run_lat(4'h0, 3, 1'b0, 12, N + 1, "vga_release");

    // Independence: UART high 5 edges, VS high 12 edges, started together.
    lat_vs = -1;
    uart_chg = 0;
    for (int k = 0; k < 25; k++) begin
      b = 4'h0;
      b[2] = (k < 5);
      b[1] = (k < 12);
      step(1'b0, b);
      o = outs();
      if (lat_vs < 0 && o[1]) lat_vs = k;
      if (o[2]) uart_chg = 1;
    end
    chk("indep_vs", lat_vs, N + 1);
    chk("indep_uart", uart_chg, 0);
    chk("indep_vs_back", outs(), 0);

    // Reset mid-count on btnVS.
    run_lat(4'h2, 1, 1'b1, 5, -1, "midrst_pre");
    step(1'b1, 4'h2);
    chk("midrst_out", outs(), 0);
    run_lat(4'h2, 1, 1'b1, 15, N + 1, "midrst_restart");
    run_lat(4'h0, 1, 1'b0, 12, N + 1, "midrst_release");

    // Randomised hold lengths per channel with occasional reset.
    rb = 4'h0;
    for (int c = 0; c < 4; c++) hold[c] = 0;
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          rb[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 2 * N + 3);
        end
        hold[c]--;
      end
      step(($urandom_range(0, 299) == 0), rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
